// File: rtl/hamsa_l0_pkg.sv
// hamsa_l0_pkg
// Shared types and constants for the L0 instruction-cache line-fill engine.
//   fill_state_e : refill FSM states
//   line_addr_t  : byte address split into tag / index / line offset, laid out
//                  the same way the L0 cache decodes its addresses
//   line_base()  : clears the offset field so any fetch address maps onto the
//                  first byte of its line
package hamsa_l0_pkg;

    localparam int          LINE_WORDS = 4;
    localparam logic [31:0] LINE_BYTES = 32'd16;
    localparam int          OFF_W      = 4;
    localparam int          IDX_W      = 6;
    localparam int          TAG_W      = 32 - IDX_W - OFF_W;

    // Last line in the 32-bit space; prefetching past it would wrap to 0.
    localparam logic [31:0] TOP_LINE   = 32'hFFFF_FFF0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_PF_CHECK,
        ST_DRAIN
    } fill_state_e;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [OFF_W-1:0] offset;
    } line_addr_t;

    function automatic line_addr_t line_base(input logic [31:0] addr);
        line_addr_t la;
        la        = addr;
        la.offset = '0;
        return la;
    endfunction

endpackage

// File: rtl/hamsa_l0_line_fill_if.sv
// hamsa_l0_line_fill_if
// OBI-style instruction-memory read port used by the line-fill engine.
//   req    : word read request (master -> memory)
//   addr   : word-aligned byte address (master -> memory)
//   gnt    : request accepted this cycle (memory -> master)
//   rvalid : read data valid, in request order (memory -> master)
//   rdata  : read data (memory -> master)
interface hamsa_l0_line_fill_if;

    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/hamsa_l0_line_asm.sv
// hamsa_l0_line_asm
// Register bank holding the words of one cache line while it is being refilled.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en_i    : store wr_word_i into slot wr_idx_i
//   wr_idx_i   : word slot within the line
//   wr_word_i  : returned memory word
//   line_o     : assembled line, word k in bits [32k+31:32k]
module hamsa_l0_line_asm
    import hamsa_l0_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [1:0]                 wr_idx_i,
    input  logic [31:0]                wr_word_i,
    output logic [LINE_WORDS*32-1:0]   line_o
);

    logic [LINE_WORDS-1:0][31:0] words_q, words_d;

    always_comb begin
        words_d = words_q;
        if (wr_en_i) begin
            words_d[wr_idx_i] = wr_word_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q <= '0;
        end else begin
            words_q <= words_d;
        end
    end

    assign line_o = words_q;

endmodule

// File: rtl/hamsa_l0_line_fill.sv
// hamsa_l0_line_fill
// Refill engine in front of the L0 instruction cache. A demand miss fetches the
// four words of its line over the memory port, writes the assembled line into
// the cache, then optionally prefetches the next sequential line unless the
// cache reports it already resident.
//   clk, rst_n   : clock, asynchronous active-low reset
//   miss_i       : demand miss, held by the fetch stage until the line hits
//   miss_addr_i  : demand fetch address (any byte offset)
//   flush_i      : abort the current fill
//   busy_o       : engine not idle
//   mem          : instruction-memory read port (master side)
//   wr_addr_o    : line address for the cache write port
//   wr_data_o    : assembled 128-bit line
//   wr_enable_o  : one-cycle cache write strobe
//   pf_addr_o    : next-line address on the cache's match port C
//   pf_hit_i     : match port C result for pf_addr_o
module hamsa_l0_line_fill #(
    parameter bit PREFETCH_EN = 1'b1,
    parameter int LINE_WORDS  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         miss_i,
    input  logic [31:0]                  miss_addr_i,
    input  logic                         flush_i,
    output logic                         busy_o,
    hamsa_l0_line_fill_if.master         mem,
    output logic [31:0]                  wr_addr_o,
    output logic [127:0]                 wr_data_o,
    output logic                         wr_enable_o,
    output logic [31:0]                  pf_addr_o,
    input  logic                         pf_hit_i
);
    import hamsa_l0_pkg::*;

    if (LINE_WORDS != 4) begin : g_line_words_check
        $error("hamsa_l0_line_fill: LINE_WORDS must be 4");
    end

    fill_state_e state_q, state_d;
    line_addr_t  line_q, line_d;
    logic        demand_q, demand_d;
    logic [2:0]  req_cnt_q, req_cnt_d;
    logic [2:0]  rsp_cnt_q, rsp_cnt_d;

    logic [31:0] line_bits;
    logic        mem_req;
    logic        req_fire;
    logic        rsp_fire;
    logic        asm_wr_en;

    assign line_bits = line_q;

    // A flush drops the request combinationally; an ungranted request that is
    // withdrawn this way never counts as issued.
    assign mem_req   = (state_q == ST_FILL) && (req_cnt_q < 3'd4) && !flush_i;
    assign req_fire  = mem_req && mem.gnt;
    assign rsp_fire  = mem.rvalid && (rsp_cnt_q < 3'd4) &&
                       ((state_q == ST_FILL) || (state_q == ST_DRAIN));
    assign asm_wr_en = rsp_fire && (state_q == ST_FILL);

    assign mem.req   = mem_req;
    assign mem.addr  = mem_req ? (line_bits + {27'd0, req_cnt_q, 2'b00}) : 32'd0;

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        demand_d  = demand_q;
        req_cnt_d = req_fire ? (req_cnt_q + 3'd1) : req_cnt_q;
        rsp_cnt_d = rsp_fire ? (rsp_cnt_q + 3'd1) : rsp_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (miss_i && !flush_i) begin
                    line_d    = line_base(miss_addr_i);
                    demand_d  = 1'b1;
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                // Responses already owed for granted requests must be drained
                // before the port can be reused.
                if (flush_i) begin
                    state_d = (rsp_cnt_d == req_cnt_q) ? ST_IDLE : ST_DRAIN;
                end else if (rsp_cnt_d == 3'd4) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!flush_i && demand_q && PREFETCH_EN && (line_bits != TOP_LINE)) begin
                    state_d = ST_PF_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PF_CHECK: begin
                if (flush_i || pf_hit_i) begin
                    state_d = ST_IDLE;
                end else begin
                    line_d    = line_addr_t'(line_bits + LINE_BYTES);
                    demand_d  = 1'b0;
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                    state_d   = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (rsp_cnt_d == req_cnt_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            line_q    <= '0;
            demand_q  <= 1'b0;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            demand_q  <= demand_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
        end
    end

    hamsa_l0_line_asm u_line_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (asm_wr_en),
        .wr_idx_i  (rsp_cnt_q[1:0]),
        .wr_word_i (mem.rdata),
        .line_o    (wr_data_o)
    );

    assign busy_o      = (state_q != ST_IDLE);
    assign wr_enable_o = (state_q == ST_WRITE) && !flush_i;
    assign wr_addr_o   = (state_q == ST_WRITE) ? line_bits : 32'd0;
    assign pf_addr_o   = (state_q == ST_PF_CHECK) ? (line_bits + LINE_BYTES) : 32'd0;

endmodule

// File: tb/tb_hamsa_l0_line_fill.sv
// tb_hamsa_l0_line_fill
// Directed and randomized bench for hamsa_l0_line_fill. A memory responder
// answers the OBI port in order, a monitor logs cache writes and prefetch
// probes, and each demand miss is checked against the line and request
// sequence the bench expects from the address alone.
module tb_hamsa_l0_line_fill;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         miss_i;
    logic [31:0]  miss_addr_i;
    logic         flush_i;
    logic         busy_o;
    logic [31:0]  wr_addr_o;
    logic [127:0] wr_data_o;
    logic         wr_enable_o;
    logic [31:0]  pf_addr_o;
    logic         pf_hit_i;

    hamsa_l0_line_fill_if mem_if ();

    hamsa_l0_line_fill #(
        .PREFETCH_EN (1'b1),
        .LINE_WORDS  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .miss_i      (miss_i),
        .miss_addr_i (miss_addr_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .mem         (mem_if),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .wr_enable_o (wr_enable_o),
        .pf_addr_o   (pf_addr_o),
        .pf_hit_i    (pf_hit_i)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0]  req_log[$];
    logic [31:0]  pend[$];
    logic [31:0]  wr_addr_log[$];
    logic [127:0] wr_data_log[$];
    logic [31:0]  pf_log[$];

    bit          seq_data    = 1'b0;
    logic [31:0] salt        = 32'h1234_5678;
    bit          gnt_random  = 1'b0;
    bit          rv_random   = 1'b0;
    int          stall_left  = 0;
    int          gnt_budget  = -1;
    int          rv_budget   = -1;
    int          stray_cnt   = 0;
    int          rv_sent     = 0;
    int          hold_err    = 0;

    // Memory contents: either a simple per-word pattern or an address hash.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        if (seq_data) return 32'hA0 + {30'd0, a[3:2]};
        return (w * 32'h9E37_79B1) ^ salt;
    endfunction

    function automatic logic [127:0] line_data(input logic [31:0] l);
        return {mem_word(l + 32'd12), mem_word(l + 32'd8), mem_word(l + 32'd4), mem_word(l)};
    endfunction

    // Memory responder: grants requests and returns data in order, at least
    // one cycle after the grant.
    initial begin
        logic        hs;
        logic [31:0] a;
        mem_if.gnt    = 1'b0;
        mem_if.rvalid = 1'b0;
        mem_if.rdata  = '0;
        forever begin
            @(negedge clk);
            hs = mem_if.req && mem_if.gnt;
            a  = mem_if.addr;
            @(posedge clk);
            #1;
            if (hs) begin
                req_log.push_back(a);
                pend.push_back(a);
                if (gnt_budget > 0) gnt_budget--;
            end
            mem_if.rvalid = 1'b0;
            mem_if.rdata  = '0;
            if (pend.size() > 0) begin
                if (rv_budget != 0 && (!rv_random || $urandom_range(0, 1) == 1)) begin
                    a = pend.pop_front();
                    mem_if.rvalid = 1'b1;
                    mem_if.rdata  = mem_word(a);
                    rv_sent++;
                    if (rv_budget > 0) rv_budget--;
                end
            end else if (stray_cnt > 0) begin
                mem_if.rvalid = 1'b1;
                mem_if.rdata  = $urandom;
                stray_cnt--;
            end
            mem_if.gnt = 1'b1;
            if (gnt_random) mem_if.gnt = ($urandom_range(0, 1) == 1);
            if (stall_left > 0 && mem_if.req && mem_if.addr[3:2] == 2'd2) begin
                mem_if.gnt = 1'b0;
                stall_left--;
            end
            if (gnt_budget == 0) mem_if.gnt = 1'b0;
        end
    end

    // Monitor: cache writes, prefetch probes, and request stability while
    // waiting for a grant.
    initial begin
        bit          wait_prev = 1'b0;
        logic [31:0] prev_addr = '0;
        forever begin
            @(negedge clk);
            if (wr_enable_o) begin
                wr_addr_log.push_back(wr_addr_o);
                wr_data_log.push_back(wr_data_o);
            end
            if (pf_addr_o != 32'd0) pf_log.push_back(pf_addr_o);
            if (wait_prev && rst_n && !flush_i &&
                (!mem_if.req || mem_if.addr != prev_addr)) hold_err++;
            wait_prev = mem_if.req && !mem_if.gnt;
            prev_addr = mem_if.addr;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit miss, input logic [31:0] addr,
                                 input bit hit, input bit flush);
        @(posedge clk);
        #1;
        miss_i      = miss;
        miss_addr_i = addr;
        pf_hit_i    = hit;
        flush_i     = flush;
    endtask

    task automatic clearLogs();
        req_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        pf_log.delete();
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy_o && pend.size() == 0) break;
        end
        checkOutput("idle_busy", 128'(busy_o), 128'(1'b0));
        checkOutput("idle_pending", 128'(pend.size()), 128'(0));
    endtask

    // Expected traffic for one demand miss: the demand line, then the next
    // line's probe unless at the top of memory, then its fill on a probe miss.
    task automatic compareLogs(input logic [31:0] l, input bit hit);
        logic [31:0]  exp_req[$];
        logic [31:0]  exp_wa[$];
        logic [127:0] exp_wd[$];
        logic [31:0]  exp_pf[$];
        logic [31:0]  nxt;
        nxt = l + 32'd16;
        for (int k = 0; k < 4; k++) exp_req.push_back(l + 32'(4 * k));
        exp_wa.push_back(l);
        exp_wd.push_back(line_data(l));
        if (l != 32'hFFFF_FFF0) begin
            exp_pf.push_back(nxt);
            if (!hit) begin
                for (int k = 0; k < 4; k++) exp_req.push_back(nxt + 32'(4 * k));
                exp_wa.push_back(nxt);
                exp_wd.push_back(line_data(nxt));
            end
        end
        checkOutput("req_count", 128'(req_log.size()), 128'(exp_req.size()));
        for (int i = 0; i < exp_req.size() && i < req_log.size(); i++)
            checkOutput($sformatf("req_addr[%0d]", i), 128'(req_log[i]), 128'(exp_req[i]));
        checkOutput("write_count", 128'(wr_addr_log.size()), 128'(exp_wa.size()));
        for (int i = 0; i < exp_wa.size() && i < wr_addr_log.size(); i++) begin
            checkOutput($sformatf("wr_addr[%0d]", i), 128'(wr_addr_log[i]), 128'(exp_wa[i]));
            checkOutput($sformatf("wr_data[%0d]", i), wr_data_log[i], exp_wd[i]);
        end
        checkOutput("pf_count", 128'(pf_log.size()), 128'(exp_pf.size()));
        for (int i = 0; i < exp_pf.size() && i < pf_log.size(); i++)
            checkOutput($sformatf("pf_addr[%0d]", i), 128'(pf_log[i]), 128'(exp_pf[i]));
        checkOutput("addr_hold", 128'(hold_err), 128'(0));
    endtask

    task automatic doMiss(input logic [31:0] addr, input bit hit, output int lat);
        logic [31:0] l;
        bit          seen;
        l    = {addr[31:4], 4'b0000};
        seen = 1'b0;
        lat  = -1;
        clearLogs();
        applyStimulus(1'b1, addr, hit, 1'b0);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (wr_enable_o && wr_addr_o == l) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
        end
        checkOutput("demand_write_seen", 128'(seen), 128'(1'b1));
        applyStimulus(1'b0, addr, hit, 1'b0);
        waitIdle();
        compareLogs(l, hit);
    endtask

    task automatic flushTest();
        bit ok;
        ok = 1'b0;
        clearLogs();
        rv_sent    = 0;
        gnt_budget = 3;
        rv_budget  = 1;
        applyStimulus(1'b1, 32'h0000_4000, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #2;
            if (req_log.size() == 3 && rv_sent == 1) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("flush_setup", 128'(ok), 128'(1'b1));
        miss_i     = 1'b0;
        flush_i    = 1'b1;
        gnt_budget = -1;
        rv_budget  = -1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        checkOutput("flush_draining_busy", 128'(busy_o), 128'(1'b1));
        waitIdle();
        checkOutput("flush_req_count", 128'(req_log.size()), 128'(3));
        checkOutput("flush_no_write", 128'(wr_addr_log.size()), 128'(0));
        checkOutput("flush_rvalids", 128'(rv_sent), 128'(3));
    endtask

    task automatic resetTest();
        bit ok;
        bit any_busy;
        bit any_wr;
        ok       = 1'b0;
        any_busy = 1'b0;
        any_wr   = 1'b0;
        clearLogs();
        applyStimulus(1'b1, 32'h0000_5000, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #2;
            if (req_log.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("reset_setup", 128'(ok), 128'(1'b1));
        rst_n  = 1'b0;
        miss_i = 1'b0;
        #1;
        checkOutput("rst_busy", 128'(busy_o), 128'(0));
        checkOutput("rst_req", 128'(mem_if.req), 128'(0));
        checkOutput("rst_addr", 128'(mem_if.addr), 128'(0));
        checkOutput("rst_wr_en", 128'(wr_enable_o), 128'(0));
        checkOutput("rst_wr_addr", 128'(wr_addr_o), 128'(0));
        checkOutput("rst_wr_data", wr_data_o, 128'(0));
        checkOutput("rst_pf_addr", 128'(pf_addr_o), 128'(0));
        repeat (2) @(posedge clk);
        #2;
        rst_n     = 1'b1;
        stray_cnt = 3;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy_o) any_busy = 1'b1;
            if (wr_enable_o) any_wr = 1'b1;
        end
        checkOutput("stray_busy", 128'(any_busy), 128'(0));
        checkOutput("stray_write", 128'(any_wr), 128'(0));
        checkOutput("stray_line_data", wr_data_o, 128'(0));
        clearLogs();
    endtask

    initial begin
        int          lat;
        logic [31:0] addr;
        bit          hit;

        rst_n       = 1'b0;
        miss_i      = 1'b0;
        miss_addr_i = '0;
        flush_i     = 1'b0;
        pf_hit_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 128'(busy_o), 128'(0));
        checkOutput("reset_req", 128'(mem_if.req), 128'(0));
        checkOutput("reset_wr_en", 128'(wr_enable_o), 128'(0));
        checkOutput("reset_wr_data", wr_data_o, 128'(0));
        checkOutput("reset_pf_addr", 128'(pf_addr_o), 128'(0));
        rst_n = 1'b1;

        $display("[TB] single fill, probe hit");
        seq_data = 1'b1;
        doMiss(32'h0000_1238, 1'b1, lat);
        checkOutput("fill_latency", 128'(lat), 128'(6));
        if (wr_data_log.size() > 0)
            checkOutput("fill_line_pattern", wr_data_log[0],
                        128'h000000A3_000000A2_000000A1_000000A0);

        $display("[TB] prefetch miss then prefetch hit");
        seq_data = 1'b0;
        salt     = $urandom;
        doMiss(32'h0000_2000, 1'b0, lat);
        doMiss(32'h0000_2000, 1'b1, lat);

        $display("[TB] stalled grant on word 2");
        stall_left = 3;
        doMiss(32'h0000_3404, 1'b1, lat);
        checkOutput("stall_consumed", 128'(stall_left), 128'(0));

        $display("[TB] flush mid-fill");
        flushTest();

        $display("[TB] flush blocks idle miss");
        clearLogs();
        applyStimulus(1'b1, 32'h0000_6000, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("idle_flush_busy", 128'(busy_o), 128'(0));
        applyStimulus(1'b0, 32'h0000_6000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("idle_flush_busy_after", 128'(busy_o), 128'(0));
        checkOutput("idle_flush_no_req", 128'(req_log.size()), 128'(0));

        $display("[TB] top-of-memory line");
        doMiss(32'hFFFF_FFF4, 1'b0, lat);

        $display("[TB] reset mid-fill");
        resetTest();

        $display("[TB] randomized misses");
        gnt_random = 1'b1;
        rv_random  = 1'b1;
        for (int n = 0; n < 16; n++) begin
            addr = $urandom;
            if ($urandom_range(0, 3) == 0) addr = 32'hFFFF_FFE0 | ($urandom & 32'h0000_001F);
            hit  = ($urandom_range(0, 1) == 1);
            salt = $urandom;
            doMiss(addr, hit, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
